// File: rtl/bus_mux_pkg.sv
// Shared constants and helpers for the bus_mux_arb slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: arbitration mode constants, default channel geometry,
// and the select-width helper used for channel index ports.
package bus_mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_N      = 4;

    // Width of a channel index; a single channel still gets a 1-bit field.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: fixed lowest-index priority or round-robin from ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates the grant with its own load condition.
//
// Ports:
//   request  in   N   per-channel request
//   ptr      in   SW  round-robin start index (ignored in fixed mode)
//   mode     in   1   0 = fixed priority, 1 = round-robin
//   grant    out  N   one-hot grant, all zero when nothing requests
module rr_arbiter
    import bus_mux_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int SW = sel_width(N)
) (
    input  logic [N-1:0]  request,
    input  logic [SW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant
);

    logic [SW-1:0] w_start;
    logic [N-1:0]  w_upper;
    logic [N-1:0]  w_upper_first;
    logic [N-1:0]  w_all_first;

    function automatic logic [N-1:0] first_set(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) begin
            if (v[j] && (r == '0)) begin
                r[j] = 1'b1;
            end
        end
        return r;
    endfunction

    // Fixed priority is round-robin with the start pinned at channel 0.
    assign w_start = mode ? ptr : '0;

    // Requests at or above the start index; if none exist the search wraps
    // around, which is the lowest-index request overall.
    always_comb begin
        w_upper = '0;
        for (int j = 0; j < N; j++) begin
            w_upper[j] = request[j] && (SW'(j) >= w_start);
        end
    end

    assign w_upper_first = first_set(w_upper);
    assign w_all_first   = first_set(request);
    assign grant         = (|w_upper) ? w_upper_first : w_all_first;

endmodule

// File: rtl/bus_mux_arb.sv
// N-to-1 arbitrated bus mux feeding a single registered output slice.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle sustained.
// Backpressure: in_ready drops to zero while a held word is not taken.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    per-channel handshake (in_ready combinational)
//   in_data              channel i at [i*WIDTH +: WIDTH]
//   force_en/force_sel   restrict eligibility to a single channel
//   out_valid/out_ready  output handshake (out_valid registered)
//   out_data/out_sel     registered word and index of its source channel
module bus_mux_arb
    import bus_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int RR    = MODE_RR,
    localparam int SW   = sel_width(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    input  logic                 force_en,
    input  logic [SW-1:0]        force_sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_sel,
    input  logic                 out_ready
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_sel;
    logic [SW-1:0]    r_ptr;

    logic             w_load;
    logic             w_xfer;
    logic [N-1:0]     w_elig;
    logic [N-1:0]     w_grant;
    logic [WIDTH-1:0] w_sel_data;
    logic [SW-1:0]    w_sel_idx;
    logic [SW-1:0]    w_ptr_nxt;

    // Forced mode keeps only the selected channel; an out-of-range index
    // matches no bit and therefore grants nothing.
    always_comb begin
        w_elig = in_valid;
        if (force_en) begin
            for (int j = 0; j < N; j++) begin
                w_elig[j] = in_valid[j] && (force_sel == SW'(j));
            end
        end
    end

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .request (w_elig),
        .ptr     (r_ptr),
        .mode    (RR == MODE_RR),
        .grant   (w_grant)
    );

    // The slice can take a word when empty or when its word leaves this cycle.
    assign w_load   = !r_out_valid || out_ready;
    assign in_ready = (w_load && !rst) ? w_grant : '0;

    // A grant implies the channel is valid, so any ready bit is a transfer.
    assign w_xfer   = |in_ready;

    // AND-OR select of the granted channel's data and index.
    always_comb begin
        w_sel_data = '0;
        w_sel_idx  = '0;
        for (int i = 0; i < N; i++) begin
            w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
            w_sel_idx  = w_sel_idx  | (SW'(i) & {SW{w_grant[i]}});
        end
    end

    assign w_ptr_nxt = (w_sel_idx == SW'(N-1)) ? '0 : w_sel_idx + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_sel_idx;
                r_ptr       <= w_ptr_nxt;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: doc/bus_mux_arb.md
BUS_MUX_ARB -- requirements
Module: bus_mux_arb

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16, meaning the data width of every channel in bits.
REQ-002 The block SHALL provide parameter N, default 4, meaning the number of input channels (1..16).
REQ-003 The block SHALL provide parameter RR, default 1, meaning the arbitration mode: 0 = fixed priority with the lowest index winning, 1 = round-robin.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 in_valid  input  N  per-channel valid; bit i belongs to channel i.
REQ-007 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  N  per-channel accept strobe; combinational.
REQ-009 force_en  input  1  when high, only channel force_sel is eligible for grant (legacy select mode).
REQ-010 force_sel  input  SW  forced channel index, where SW = max(1, clog2(N)).
REQ-011 out_valid  output  1  registered; high while out_data holds an untaken word.
REQ-012 out_data  output  WIDTH  registered selected word.
REQ-013 out_sel  output  SW  registered index of the channel that sourced out_data.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 The block SHALL define load = !out_valid || out_ready.
REQ-016 Eligible channels SHALL be in_valid, masked to the single bit force_sel when force_en = 1.
REQ-017 When RR = 0, the block SHALL grant the lowest-index eligible channel.
REQ-018 When RR = 1, the block SHALL grant the first eligible channel at or after ptr, searching upward and wrapping from N-1 to 0.
REQ-019 At most one in_ready bit SHALL be high, and in_ready[i] SHALL be high only when grant[i] = 1 and load = 1.
REQ-020 A transfer from channel i SHALL occur on a cycle where in_valid[i] and in_ready[i] are both high; on the next edge out_data = data_i, out_sel = i and out_valid = 1.
REQ-021 Latency SHALL be 1 cycle from input transfer to out_valid.
REQ-022 Throughput SHALL be 1 word per cycle while out_ready is held high.
REQ-023 An output transfer SHALL occur when out_valid and out_ready are both high; if no new input transfer happens on the same edge, out_valid SHALL return to 0.
REQ-024 While out_valid = 1 and out_ready = 0, out_data, out_sel and out_valid SHALL hold stable and all in_ready bits SHALL be 0.
REQ-025 An output transfer and a new input transfer on the same edge SHALL replace the held word with no bubble cycle.
REQ-026 ptr SHALL update only on an input transfer, to (granted index + 1) mod N, so that index N-1 wraps to 0.
REQ-027 ptr SHALL be unused when RR = 0, and force_en SHALL NOT alter ptr except through transfers.
REQ-028 If force_en = 1 and in_valid[force_sel] = 0, the block SHALL grant no channel, including when other channels are valid.
REQ-029 A force_sel value of N or greater SHALL grant no channel.
REQ-030 With N = 1, the block SHALL behave as a one-entry register slice with out_sel fixed at 0.
REQ-031 in_ready SHALL NOT depend combinationally on out_valid except through load, and SHALL NOT depend on any in_ready.

Reset
REQ-032 On rst = 1 at a clk edge, the block SHALL set out_valid = 0, out_data = 0, out_sel = 0 and ptr = 0.
REQ-033 While rst = 1, all in_ready bits SHALL be 0.
REQ-034 A reset asserted while a word is held SHALL discard that word, and the first grant after reset SHALL start from channel 0.

Structure
REQ-035 Package bus_mux_pkg SHALL hold the clog2 width function, the mode constants MODE_FIXED = 0 and MODE_RR = 1, and the default WIDTH and N values.
REQ-036 Arbitration SHALL live in sub-module rr_arbiter (inputs: request, ptr, mode; output: one-hot grant), instantiated once.
REQ-037 The data path SHALL be an AND-OR selection of in_data by the grant, feeding a single output register stage in bus_mux_arb.

Verification
REQ-038 Reset then idle: rst for 2 cycles with in_valid = 4'b1111 -> in_ready = 0 during reset; after release out_valid = 0, out_data = 16'h0000 and out_sel = 0.
REQ-039 Round-robin fairness: RR = 1, all 4 channels valid, in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111}, out_ready = 1 -> out_sel sequence 0, 1, 2, 3, 0 on consecutive cycles with matching data.
REQ-040 Fixed priority: RR = 0, in_valid = 4'b1010 -> channel 1 is always granted and channel 3 is starved.
REQ-041 Backpressure: one word held with out_ready = 0 for 3 cycles -> out_data stable and in_ready = 0; on the out_ready pulse the next word loads on the same edge without a bubble.
REQ-042 Forced select: force_en = 1, force_sel = 2, in_valid = 4'b1011 -> no grant and out_valid = 0; then raise in_valid[2] with data 16'hBEEF -> out_data = 16'hBEEF and out_sel = 2 one cycle later.
REQ-043 Mid-operation reset: rst asserted while a word is held, with ptr = 3 -> out_valid = 0 and the next grant comes from channel 0.
